// File: rtl/dma_pkg.sv
// Shared types, register map and STAT layout for the multi-channel Venus-DMA CSR front-end.
package dma_pkg;

    localparam int DESC_CH_W = 3;

    localparam logic [5:0]  VENUSDMA_CFG_OFFSET     = 6'h00;
    localparam logic [5:0]  VENUSDMA_SRC_OFFSET     = 6'h08;
    localparam logic [5:0]  VENUSDMA_DST_OFFSET     = 6'h10;
    localparam logic [5:0]  VENUSDMA_LEN_OFFSET     = 6'h18;
    localparam logic [5:0]  VENUSDMA_STAT_OFFSET    = 6'h20;
    localparam logic [5:0]  VENUSDMA_ERRADDR_OFFSET = 6'h28;
    localparam logic [31:0] VENUSDMA_CH_STRIDE      = 32'h40;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_ERRSRC_LO = 1;
    localparam int STAT_ERR_BIT   = 3;
    localparam int STAT_BUSY_BIT  = 4;
    localparam int STAT_OVF_BIT   = 5;
    localparam int STAT_OCC_LO    = 8;

    localparam int CFG_START_BIT   = 0;
    localparam int CFG_LAST_BIT    = 1;
    localparam int CFG_CLR_IRQ_BIT = 2;
    localparam int CFG_CLR_ERR_BIT = 3;

    typedef logic [31:0] desc_addr_t;
    typedef logic [1:0]  err_src_t;

    typedef struct packed {
        logic        wr_en;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic        rd_en;
        logic [31:0] raddr;
    } csr_req_t;

    typedef struct packed {
        logic [511:0] rdata;
    } csr_resp_t;

    // ch is sized for the largest supported channel count (8).
    typedef struct packed {
        logic [DESC_CH_W-1:0] ch;
        desc_addr_t           src;
        desc_addr_t           dst;
        logic [31:0]          len;
        logic                 last;
    } dma_desc_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    function automatic logic [31:0] stat_word(input logic full, input err_src_t es,
                                              input logic err, input logic busy,
                                              input logic ovf, input logic [3:0] occ);
        logic [31:0] w;
        w = '0;
        w[STAT_FULL_BIT]        = full;
        w[STAT_ERRSRC_LO +: 2]  = es;
        w[STAT_ERR_BIT]         = err;
        w[STAT_BUSY_BIT]        = busy;
        w[STAT_OVF_BIT]         = ovf;
        w[STAT_OCC_LO +: 4]     = occ;
        return w;
    endfunction

endpackage

// File: rtl/dma_desc_fifo.sv
// Per-channel descriptor FIFO: show-ahead read data, push ignored when full, pop ignored when empty.
module dma_desc_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign rdata = mem_q[rd_ptr_q];
    assign count = cnt_q;

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/dma_ctrls_mc.sv
// Multi-channel CSR front-end: per-channel register windows and descriptor FIFOs,
// round-robin issue to the engine, in-flight tracking, completion IRQs and error capture.
import dma_pkg::*;

module dma_ctrls_mc #(
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int INFL_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  csr_req_t          dma_csr_req_i,
    output csr_resp_t         dma_csr_resp_o,
    // Descriptor port: a descriptor transfers on any cycle with desc_valid_o && desc_ready_i;
    // once valid is raised, desc_o and valid hold until that handshake.
    output logic              desc_valid_o,
    input  logic              desc_ready_i,
    output dma_desc_t         desc_o,
    input  logic              done_valid_i,
    input  logic [CH_W-1:0]   done_ch_i,
    input  logic              done_last_i,
    input  logic              err_valid_i,
    input  logic [CH_W-1:0]   err_ch_i,
    input  desc_addr_t        err_addr_i,
    input  err_src_t          err_src_i,
    output logic [NUM_CH-1:0] irq_o,
    output logic [NUM_CH-1:0] err_irq_o,
    output arb_state_e        arb_state_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [INFL_W-1:0] INFL_MAX = '1;
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);

    logic [31:0]       src_q [NUM_CH], src_d [NUM_CH];
    logic [31:0]       dst_q [NUM_CH], dst_d [NUM_CH];
    logic [31:0]       len_q [NUM_CH], len_d [NUM_CH];
    desc_addr_t        err_addr_q [NUM_CH], err_addr_d [NUM_CH];
    err_src_t          err_src_q [NUM_CH], err_src_d [NUM_CH];
    logic [INFL_W-1:0] infl_q [NUM_CH], infl_d [NUM_CH];
    logic [NUM_CH-1:0] err_q, err_d, ovf_q, ovf_d, irq_q, irq_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    arb_state_e        state_q, state_d;
    dma_desc_t         desc_q, desc_d;
    logic [511:0]      rdata_q, rdata_d;

    logic [NUM_CH-1:0] fifo_push, fifo_pop, fifo_full, fifo_empty;
    dma_desc_t         fifo_wdata;
    dma_desc_t         fifo_rdata [NUM_CH];
    logic [CNT_W-1:0]  fifo_cnt [NUM_CH];

    logic [CH_W-1:0]   wr_ch, rd_ch, held_ch, gnt_ch;
    logic [5:0]        wr_off;
    logic              wr_hit, rd_hit, hs, gnt_found;
    logic [NUM_CH-1:0] elig, busy;
    logic [31:0]       stat [NUM_CH];
    logic              unused_addr_bits;

    assign wr_ch   = dma_csr_req_i.waddr[6 +: CH_W];
    assign wr_off  = dma_csr_req_i.waddr[5:0];
    assign rd_ch   = dma_csr_req_i.raddr[6 +: CH_W];
    assign wr_hit  = dma_csr_req_i.wr_en && (int'(wr_ch) < NUM_CH);
    assign rd_hit  = dma_csr_req_i.rd_en && (int'(rd_ch) < NUM_CH);
    assign held_ch = desc_q.ch[CH_W-1:0];
    assign hs      = (state_q == ARB_HOLD) && desc_ready_i;
    assign unused_addr_bits = ^{dma_csr_req_i.waddr[31:6+CH_W], dma_csr_req_i.raddr[31:6+CH_W],
                                dma_csr_req_i.raddr[5:0]};

    // A START pushes the shadows as they stood before this cycle's write.
    always_comb begin
        fifo_wdata      = '0;
        fifo_wdata.ch   = DESC_CH_W'(wr_ch);
        fifo_wdata.src  = src_q[wr_ch];
        fifo_wdata.dst  = dst_q[wr_ch];
        fifo_wdata.len  = len_q[wr_ch];
        fifo_wdata.last = dma_csr_req_i.wdata[CFG_LAST_BIT];
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
        dma_desc_fifo #(
            .W     ($bits(dma_desc_t)),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (fifo_push[g]),
            .pop   (fifo_pop[g]),
            .wdata (fifo_wdata),
            .rdata (fifo_rdata[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g]),
            .count (fifo_cnt[g])
        );
    end

    always_comb begin
        elig = '0;
        busy = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            elig[c] = !fifo_empty[c] && (infl_q[c] != INFL_MAX);
            busy[c] = !fifo_empty[c] || (infl_q[c] != '0) ||
                      ((state_q == ARB_HOLD) && (int'(held_ch) == c));
            stat[c] = stat_word(fifo_full[c], err_src_q[c], err_q[c], busy[c], ovf_q[c],
                                4'(fifo_cnt[c]));
        end
    end

    always_comb begin
        gnt_found = 1'b0;
        gnt_ch    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!gnt_found && elig[(int'(rr_ptr_q) + k) % NUM_CH]) begin
                gnt_found = 1'b1;
                gnt_ch    = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        desc_d   = desc_q;
        rr_ptr_d = rr_ptr_q;
        fifo_pop = '0;
        case (state_q)
            ARB_IDLE: begin
                if (gnt_found) begin
                    fifo_pop[gnt_ch] = 1'b1;
                    desc_d           = fifo_rdata[gnt_ch];
                    state_d          = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (desc_ready_i) begin
                    rr_ptr_d = (held_ch == LAST_CH) ? '0 : held_ch + 1'b1;
                    state_d  = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Clears are applied first so that a same-cycle set always wins.
    always_comb begin
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        err_addr_d = err_addr_q;
        err_src_d  = err_src_q;
        infl_d     = infl_q;
        err_d      = err_q;
        ovf_d      = ovf_q;
        irq_d      = irq_q;
        fifo_push  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_hit && (int'(wr_ch) == c)) begin
                case (wr_off)
                    VENUSDMA_SRC_OFFSET: src_d[c] = dma_csr_req_i.wdata;
                    VENUSDMA_DST_OFFSET: dst_d[c] = dma_csr_req_i.wdata;
                    VENUSDMA_LEN_OFFSET: len_d[c] = dma_csr_req_i.wdata;
                    VENUSDMA_CFG_OFFSET: begin
                        if (dma_csr_req_i.wdata[CFG_CLR_IRQ_BIT]) irq_d[c] = 1'b0;
                        if (dma_csr_req_i.wdata[CFG_CLR_ERR_BIT]) begin
                            err_d[c] = 1'b0;
                            ovf_d[c] = 1'b0;
                        end
                        if (dma_csr_req_i.wdata[CFG_START_BIT]) begin
                            if (fifo_full[c]) ovf_d[c] = 1'b1;
                            else              fifo_push[c] = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (done_valid_i && done_last_i && (int'(done_ch_i) == c)) irq_d[c] = 1'b1;
            if (err_valid_i && (int'(err_ch_i) == c)) begin
                err_d[c]      = 1'b1;
                err_addr_d[c] = err_addr_i;
                err_src_d[c]  = err_src_i;
            end
            if (hs && (int'(held_ch) == c) &&
                !(done_valid_i && (int'(done_ch_i) == c) && (infl_q[c] != '0))) begin
                if (infl_q[c] != INFL_MAX) infl_d[c] = infl_q[c] + 1'b1;
            end else if (!(hs && (int'(held_ch) == c)) && done_valid_i &&
                         (int'(done_ch_i) == c) && (infl_q[c] != '0)) begin
                infl_d[c] = infl_q[c] - 1'b1;
            end
        end
    end

    always_comb begin
        rdata_d = '0;
        if (rd_hit) begin
            rdata_d = {320'h0, err_addr_q[rd_ch], stat[rd_ch], len_q[rd_ch], dst_q[rd_ch],
                       src_q[rd_ch], 32'h0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                src_q[c]      <= '0;
                dst_q[c]      <= '0;
                len_q[c]      <= '0;
                err_addr_q[c] <= '0;
                err_src_q[c]  <= '0;
                infl_q[c]     <= '0;
            end
            err_q    <= '0;
            ovf_q    <= '0;
            irq_q    <= '0;
            rr_ptr_q <= '0;
            state_q  <= ARB_IDLE;
            desc_q   <= '0;
            rdata_q  <= '0;
        end else begin
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            err_addr_q <= err_addr_d;
            err_src_q  <= err_src_d;
            infl_q     <= infl_d;
            err_q      <= err_d;
            ovf_q      <= ovf_d;
            irq_q      <= irq_d;
            rr_ptr_q   <= rr_ptr_d;
            state_q    <= state_d;
            desc_q     <= desc_d;
            rdata_q    <= rdata_d;
        end
    end

    assign desc_valid_o         = (state_q == ARB_HOLD);
    assign desc_o               = desc_q;
    assign irq_o                = irq_q;
    assign err_irq_o            = err_q;
    assign dma_csr_resp_o.rdata = rdata_q;
    assign arb_state_o          = state_q;

endmodule

// File: tb/tb_dma_ctrls_mc.sv
// Directed bench for dma_ctrls_mc: register windows, issue order, hold, overflow, IRQ and error capture.
module tb_dma_ctrls_mc;
    import dma_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              rst;
    csr_req_t          req;
    csr_resp_t         resp;
    logic              desc_valid;
    logic              desc_ready;
    dma_desc_t         desc;
    logic              done_valid;
    logic [CH_W-1:0]   done_ch;
    logic              done_last;
    logic              err_valid;
    logic [CH_W-1:0]   err_ch;
    desc_addr_t        err_addr;
    err_src_t          err_src;
    logic [NUM_CH-1:0] irq;
    logic [NUM_CH-1:0] err_irq;
    arb_state_e        arb_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    logic [2:0]  exp_ch_q[$];

    dma_ctrls_mc #(
        .NUM_CH     (NUM_CH),
        .FIFO_DEPTH (4),
        .CH_W       (CH_W),
        .INFL_W     (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dma_csr_req_i  (req),
        .dma_csr_resp_o (resp),
        .desc_valid_o   (desc_valid),
        .desc_ready_i   (desc_ready),
        .desc_o         (desc),
        .done_valid_i   (done_valid),
        .done_ch_i      (done_ch),
        .done_last_i    (done_last),
        .err_valid_i    (err_valid),
        .err_ch_i       (err_ch),
        .err_addr_i     (err_addr),
        .err_src_i      (err_src),
        .irq_o          (irq),
        .err_irq_o      (err_irq),
        .arb_state_o    (arb_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        req        = '0;
        desc_ready = 1'b0;
        done_valid = 1'b0;
        done_ch    = '0;
        done_last  = 1'b0;
        err_valid  = 1'b0;
        err_ch     = '0;
        err_addr   = '0;
        err_src    = '0;
    endtask

    task automatic csr_write(input int ch, input logic [5:0] off, input logic [31:0] data);
        @(negedge clk);
        req.wr_en = 1'b1;
        req.waddr = 32'(ch) * VENUSDMA_CH_STRIDE + 32'(off);
        req.wdata = data;
        @(negedge clk);
        req.wr_en = 1'b0;
    endtask

    task automatic csr_read(input int ch, output logic [511:0] d);
        @(negedge clk);
        req.rd_en = 1'b1;
        req.raddr = 32'(ch) * VENUSDMA_CH_STRIDE;
        @(negedge clk);
        req.rd_en = 1'b0;
        d = resp.rdata;
    endtask

    task automatic pulse_done(input int ch, input logic last);
        @(negedge clk);
        done_valid = 1'b1;
        done_ch    = CH_W'(ch);
        done_last  = last;
        @(negedge clk);
        done_valid = 1'b0;
        done_last  = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int cyc;
        cyc = 0;
        while (desc_valid !== 1'b1 && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (desc_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s: desc_valid=%b after %0d cycles, required 1", name, desc_valid, cyc);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [511:0] d;
        drive_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (desc_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %b required 0", desc_valid);
        end
        n_cmp++;
        if (irq !== 4'b0000 || err_irq !== 4'b0000) begin
            n_err++; $display("FAIL reset_irq: irq=%b err_irq=%b required 0000/0000", irq, err_irq);
        end
        n_cmp++;
        if (desc !== '0) begin
            n_err++; $display("FAIL reset_desc: got %h required 0", desc);
        end
        csr_read(0, d);
        n_cmp++;
        if (d !== '0) begin
            n_err++; $display("FAIL reset_ch0_window: stat=%h erraddr=%h required 0", d[159:128], d[191:160]);
        end
    endtask

    task automatic test_single_issue();
        logic [511:0] d;
        dma_desc_t    e;
        desc_ready = 1'b1;
        csr_write(1, VENUSDMA_SRC_OFFSET, 32'h1000);
        csr_write(1, VENUSDMA_DST_OFFSET, 32'h2000);
        csr_write(1, VENUSDMA_LEN_OFFSET, 32'h40);
        csr_write(1, VENUSDMA_CFG_OFFSET, 32'h3);
        wait_valid("single_valid");
        e = '{ch: 3'd1, src: 32'h1000, dst: 32'h2000, len: 32'h40, last: 1'b1};
        n_cmp++;
        if (desc !== e) begin
            n_err++; $display("FAIL single_desc: got %h required %h", desc, e);
        end
        @(negedge clk);
        csr_read(1, d);
        n_cmp++;
        if (d[159:128] !== 32'h10) begin
            n_err++; $display("FAIL single_stat_busy: got %h required 00000010", d[159:128]);
        end
        n_cmp++;
        if (d[63:32] !== 32'h1000 || d[95:64] !== 32'h2000 || d[127:96] !== 32'h40 ||
            d[31:0] !== 32'h0 || d[511:160] !== '0) begin
            n_err++; $display("FAIL single_window: src=%h dst=%h len=%h cfg=%h required 1000/2000/40/0",
                              d[63:32], d[95:64], d[127:96], d[31:0]);
        end
        pulse_done(1, 1'b1);
        n_cmp++;
        if (irq !== 4'b0010) begin
            n_err++; $display("FAIL done_irq_set: got %b required 0010", irq);
        end
        csr_write(1, VENUSDMA_CFG_OFFSET, 32'h4);
        n_cmp++;
        if (irq !== 4'b0000) begin
            n_err++; $display("FAIL irq_clear: got %b required 0000", irq);
        end
        csr_read(1, d);
        n_cmp++;
        if (d[159:128] !== 32'h0) begin
            n_err++; $display("FAIL single_stat_idle: got %h required 00000000", d[159:128]);
        end
        desc_ready = 1'b0;
    endtask

    // ch3 is parked in the output register first so ch0's FIFO sees all five STARTs.
    task automatic test_overflow_and_hold();
        logic [511:0] d;
        dma_desc_t    e;
        desc_ready = 1'b0;
        csr_write(3, VENUSDMA_SRC_OFFSET, 32'h3300);
        csr_write(3, VENUSDMA_CFG_OFFSET, 32'h1);
        wait_valid("hold_valid");
        e = '{ch: 3'd3, src: 32'h3300, dst: 32'h0, len: 32'h0, last: 1'b0};
        for (int i = 0; i < 5; i++) csr_write(0, VENUSDMA_CFG_OFFSET, 32'h1);
        csr_read(0, d);
        n_cmp++;
        if (d[159:128] !== 32'h431) begin
            n_err++; $display("FAIL ovf_stat: got %h required 00000431", d[159:128]);
        end
        csr_write(0, VENUSDMA_CFG_OFFSET, 32'h8);
        csr_read(0, d);
        n_cmp++;
        if (d[159:128] !== 32'h411) begin
            n_err++; $display("FAIL ovf_clear_stat: got %h required 00000411", d[159:128]);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (desc_valid !== 1'b1 || desc !== e) begin
                n_err++; $display("FAIL hold_stable cycle %0d: valid=%b desc=%h required 1/%h",
                                  i, desc_valid, desc, e);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (desc_valid !== 1'b0 || desc !== '0) begin
            n_err++; $display("FAIL reset_in_hold: valid=%b desc=%h required 0/0", desc_valid, desc);
        end
        @(negedge clk);
        rst = 1'b0;
        csr_read(0, d);
        n_cmp++;
        if (d[159:128] !== 32'h0) begin
            n_err++; $display("FAIL reset_flush_stat: got %h required 00000000", d[159:128]);
        end
    endtask

    task automatic test_round_robin();
        int cyc;
        int got;
        int chs[3];
        chs = '{0, 2, 3};
        desc_ready = 1'b0;
        for (int ci = 0; ci < 3; ci++) begin
            for (int k = 0; k < 2; k++) begin
                csr_write(chs[ci], VENUSDMA_SRC_OFFSET, 32'hA000 + 32'(chs[ci] * 16 + k));
                csr_write(chs[ci], VENUSDMA_CFG_OFFSET, 32'h1);
            end
        end
        for (int k = 0; k < 2; k++) begin
            for (int ci = 0; ci < 3; ci++) begin
                exp_q.push_back(32'hA000 + 32'(chs[ci] * 16 + k));
                exp_ch_q.push_back(3'(chs[ci]));
            end
        end
        desc_ready = 1'b1;
        cyc = 0;
        got = 0;
        while (got < 6 && cyc < 40) begin
            if (desc_valid === 1'b1) begin
                logic [31:0] es;
                logic [2:0]  ec;
                es = exp_q.pop_front();
                ec = exp_ch_q.pop_front();
                n_cmp++;
                if (desc.ch !== ec || desc.src !== es) begin
                    n_err++; $display("FAIL rr_grant %0d: ch=%0d src=%h required ch=%0d src=%h",
                                      got, desc.ch, desc.src, ec, es);
                end
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (got != 6) begin
            n_err++; $display("FAIL rr_count: got %0d grants required 6", got);
        end
        desc_ready = 1'b0;
        pulse_done(3, 1'b0);
        pulse_done(3, 1'b0);
        n_cmp++;
        if (irq !== 4'b0000) begin
            n_err++; $display("FAIL done_nolast_irq: got %b required 0000", irq);
        end
    endtask

    task automatic test_error_capture();
        logic [511:0] d;
        @(negedge clk);
        req.wr_en = 1'b1;
        req.waddr = 32'd3 * VENUSDMA_CH_STRIDE + 32'(VENUSDMA_CFG_OFFSET);
        req.wdata = 32'h8;
        err_valid = 1'b1;
        err_ch    = 2'd3;
        err_addr  = 32'hDEAD_BEEC;
        err_src   = 2'b10;
        @(negedge clk);
        req.wr_en = 1'b0;
        err_valid = 1'b0;
        n_cmp++;
        if (err_irq !== 4'b1000) begin
            n_err++; $display("FAIL err_irq_set: got %b required 1000", err_irq);
        end
        csr_read(3, d);
        n_cmp++;
        if (d[191:160] !== 32'hDEAD_BEEC) begin
            n_err++; $display("FAIL err_addr: got %h required deadbeec", d[191:160]);
        end
        n_cmp++;
        if (d[159:128] !== 32'h0C) begin
            n_err++; $display("FAIL err_stat: got %h required 0000000c", d[159:128]);
        end
        csr_write(3, VENUSDMA_CFG_OFFSET, 32'h8);
        n_cmp++;
        if (err_irq !== 4'b0000) begin
            n_err++; $display("FAIL err_irq_clear: got %b required 0000", err_irq);
        end
        csr_read(3, d);
        n_cmp++;
        if (d[159:128] !== 32'h04) begin
            n_err++; $display("FAIL err_stat_after_clear: got %h required 00000004", d[159:128]);
        end
    endtask

    initial begin
        test_reset();
        test_single_issue();
        test_overflow_and_hold();
        test_round_robin();
        test_error_capture();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
